// File: rtl/sobel_window_buffer.sv
// 3x3 neighbourhood generator for the Sobel pipeline, two line buffers.
// Optional SOBEL_WIN_POS_EN adds row_o/col_o window-centre outputs.
module sobel_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 5,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] grayscale_i,
  input  logic              done_i,
  input  logic              start_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic [DATA_W-1:0] d3_o,
  output logic [DATA_W-1:0] d4_o,
  output logic [DATA_W-1:0] d5_o,
  output logic [DATA_W-1:0] d6_o,
  output logic [DATA_W-1:0] d7_o,
  output logic [DATA_W-1:0] d8_o,
`ifdef SOBEL_WIN_POS_EN
  output logic [RW-1:0]     row_o,
  output logic [CW-1:0]     col_o,
`endif
  output logic              done_o,
  output logic              frame_done_o
);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_lb2 [IMG_W];
  logic [DATA_W-1:0] r_win [9];
  logic [DATA_W-1:0] r_d   [9];
  logic              r_done;
  logic              r_fd;

  logic [CW-1:0]     w_c;
  logic [RW-1:0]     w_r;
  logic [CW-1:0]     w_c_nxt;
  logic [RW-1:0]     w_r_nxt;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_vld;
  logic [DATA_W-1:0] w_win [9];

  // start_i forces the accepted pixel to (0,0) whatever the counters say
  assign w_c = start_i ? '0 : r_col;
  assign w_r = start_i ? '0 : r_row;
  assign w_last_col = (w_c == CW'(IMG_W - 1));
  assign w_last_row = (w_r == RW'(IMG_H - 1));
  assign w_vld = (w_r >= RW'(2)) && (w_c >= CW'(2));

  always_comb begin
    w_c_nxt = w_c + CW'(1);
    w_r_nxt = w_r;
    if (w_last_col) begin
      w_c_nxt = '0;
      w_r_nxt = w_last_row ? '0 : w_r + RW'(1);
    end
  end

  always_comb begin
    w_win[0] = r_win[1];
    w_win[1] = r_win[2];
    w_win[2] = r_lb2[w_c];
    w_win[3] = r_win[4];
    w_win[4] = r_win[5];
    w_win[5] = r_lb1[w_c];
    w_win[6] = r_win[7];
    w_win[7] = r_win[8];
    w_win[8] = grayscale_i;
  end

  always_ff @(posedge clk) begin
    if (done_i && !rst) begin
      r_lb2[w_c] <= r_lb1[w_c];
      r_lb1[w_c] <= grayscale_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
      r_fd   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_d[i]   <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_fd   <= 1'b0;
      if (done_i) begin
        r_col <= w_c_nxt;
        r_row <= w_r_nxt;
        for (int i = 0; i < 9; i++)
          r_win[i] <= w_win[i];
        if (w_vld) begin
          r_done <= 1'b1;
          for (int i = 0; i < 9; i++)
            r_d[i] <= w_win[i];
        end
        r_fd <= w_last_col && w_last_row;
      end
    end
  end

`ifdef SOBEL_WIN_POS_EN
  logic [RW-1:0] r_row_o;
  logic [CW-1:0] r_col_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_o <= '0;
      r_col_o <= '0;
    end else if (done_i && w_vld) begin
      r_row_o <= w_r - RW'(1);
      r_col_o <= w_c - CW'(1);
    end
  end

  assign row_o = r_row_o;
  assign col_o = r_col_o;
`endif

  assign d0_o = r_d[0];
  assign d1_o = r_d[1];
  assign d2_o = r_d[2];
  assign d3_o = r_d[3];
  assign d4_o = r_d[4];
  assign d5_o = r_d[5];
  assign d6_o = r_d[6];
  assign d7_o = r_d[7];
  assign d8_o = r_d[8];
  assign done_o = r_done;
  assign frame_done_o = r_fd;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer: a frame-array model predicts
// every window; outputs are sampled on the falling edge.
module tb_sobel_window_buffer;

  localparam int DW = 8;
  localparam int W  = 6;
  localparam int H  = 5;

  typedef struct packed {
    logic [9*DW-1:0] d;
    logic            fd;
    logic [2:0]      row;
    logic [2:0]      col;
  } exp_t;

  logic          clk = 0;
  logic          rst;
  logic [DW-1:0] gray;
  logic          done_i;
  logic          start_i;
  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic          done_o;
  logic          fd_o;
`ifdef SOBEL_WIN_POS_EN
  logic [2:0]    row_o;
  logic [2:0]    col_o;
`endif

  sobel_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst(rst), .grayscale_i(gray),
    .done_i(done_i), .start_i(start_i),
    .d0_o(d0), .d1_o(d1), .d2_o(d2), .d3_o(d3), .d4_o(d4),
    .d5_o(d5), .d6_o(d6), .d7_o(d7), .d8_o(d8),
`ifdef SOBEL_WIN_POS_EN
    .row_o(row_o), .col_o(col_o),
`endif
    .done_o(done_o), .frame_done_o(fd_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] win9(
    input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [9*DW-1:0] v;
    v = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4),
         DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    return v;
  endfunction

  // reference model: full-frame pixel array indexed by position
  logic [DW-1:0]   img [H][W];
  exp_t            q[$];
  int              mr = 0;
  int              mc = 0;
  bit              acc_prev = 0;
  bit              rst_seen = 1;
  logic [9*DW-1:0] last_win = '0;
  logic [9*DW-1:0] first_win;
  logic [9*DW-1:0] final_win;
  logic            final_fd;
  int              n_win = 0;

  always @(posedge clk) begin
    int r, c;
    exp_t e;
    rst_seen = rst;
    acc_prev = 0;
    if (rst) begin
      mr = 0;
      mc = 0;
    end else if (done_i) begin
      acc_prev = 1;
      r = start_i ? 0 : mr;
      c = start_i ? 0 : mc;
      img[r][c] = gray;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.d[(i*3+j)*DW +: DW] = img[r-2+i][c-2+j];
        e.fd  = (r == H-1) && (c == W-1);
        e.row = 3'(r - 1);
        e.col = 3'(c - 1);
        q.push_back(e);
      end
      c++;
      if (c == W) begin
        c = 0;
        r = (r == H-1) ? 0 : r + 1;
      end
      mr = r;
      mc = c;
    end
  end

  always @(negedge clk) begin
    logic [9*DW-1:0] obs;
    exp_t e;
    obs = {d8, d7, d6, d5, d4, d3, d2, d1, d0};
    if (rst_seen) begin
      last_win = '0;
    end else if (done_o) begin
      if (!acc_prev)
        chk("pulse_without_accept", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_window", 1, 0);
      end else begin
        e = q.pop_front();
        chk("window", obs, e.d);
        chk("frame_done", fd_o, e.fd);
`ifdef SOBEL_WIN_POS_EN
        chk("row", row_o, e.row);
        chk("col", col_o, e.col);
`endif
        if (n_win == 0)
          first_win = obs;
        final_win = obs;
        final_fd  = fd_o;
        last_win  = e.d;
        n_win++;
      end
    end else begin
      chk("hold", obs, last_win);
      chk("frame_done_idle", fd_o, 0);
    end
  end

  task automatic px(input int v, input bit st);
    @(posedge clk);
    #1;
    done_i  = 1;
    start_i = st;
    gray    = DW'(v);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    done_i  = 0;
    start_i = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {d8, d7, d6, d5, d4, d3, d2, d1, d0, done_o, fd_o}, 0);
`ifdef SOBEL_WIN_POS_EN
    chk({tag, "_pos"}, {row_o, col_o}, 0);
`endif
  endtask

  initial begin
    rst = 1;
    done_i = 0;
    start_i = 0;
    gray = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    rst = 0;

    // continuous frame
    n_win = 0;
    for (int i = 1; i <= 30; i++) px(i, i == 1);
    idle();
    idle();
    chk("t1_count", n_win, 12);
    chk("t1_first", first_win, win9(1, 2, 3, 7, 8, 9, 13, 14, 15));
    chk("t1_last", final_win, win9(16, 17, 18, 22, 23, 24, 28, 29, 30));
    chk("t1_last_fd", final_fd, 1);

    // done_i toggling every cycle
    n_win = 0;
    for (int i = 1; i <= 30; i++) begin
      px(i, i == 1);
      idle();
    end
    idle();
    chk("t2_count", n_win, 12);
    chk("t2_first", first_win, win9(1, 2, 3, 7, 8, 9, 13, 14, 15));

    // back-to-back frames, redundant start on the second
    n_win = 0;
    for (int i = 1; i <= 60; i++) px(i, i == 1 || i == 31);
    idle();
    idle();
    chk("t3_count", n_win, 24);
    chk("t3_last", final_win, win9(46, 47, 48, 52, 53, 54, 58, 59, 60));

    // reset mid-frame, pixel offered during reset is discarded
    for (int i = 1; i <= 20; i++) px(i, i == 1);
    @(posedge clk);
    #1;
    rst = 1;
    done_i = 1;
    gray = 99;
    @(posedge clk);
    #1;
    chk_zero("midframe_reset");
    done_i = 0;
    rst = 0;
    n_win = 0;
    for (int i = 1; i <= 30; i++) px(i, 0);
    idle();
    idle();
    chk("t4_count", n_win, 12);
    chk("t4_first", first_win, win9(1, 2, 3, 7, 8, 9, 13, 14, 15));

    // start_i mid-frame resynchronises
    for (int i = 1; i <= 10; i++) px(i, i == 1);
    idle();
    n_win = 0;
    px(100, 1);
    for (int i = 101; i <= 129; i++) px(i, 0);
    idle();
    idle();
    chk("t5_count", n_win, 12);
    chk("t5_first", first_win,
        win9(100, 101, 102, 106, 107, 108, 112, 113, 114));

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
